// File: rtl/fp16_to_fp8_quantizer.sv
// Two-stage valid/ready pipeline that re-quantizes four FP16 lanes per beat to FP8 (E4M3 or E5M2) with RNE.
// Define FP8Q_SATURATE_EN to clamp overflow and inf to the max finite value instead of inf/NaN.
module fp16_to_fp8_quantizer (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        e5m2mode,
    input  logic [63:0] h,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] vec,
    output logic [3:0]  of_flags
);

`ifdef FP8Q_SATURATE_EN
    localparam logic SATURATE = 1'b1;
`else
    localparam logic SATURATE = 1'b0;
`endif

    localparam logic [1:0] CLS_ZERO = 2'd0;
    localparam logic [1:0] CLS_NORM = 2'd1;
    localparam logic [1:0] CLS_INF  = 2'd2;
    localparam logic [1:0] CLS_NAN  = 2'd3;

    localparam logic [6:0] E4M3_MAX = 7'h7E;
    localparam logic [6:0] E5M2_MAX = 7'h7B;
    localparam logic [6:0] E5M2_INF = 7'h7C;
    localparam logic [6:0] FP8_NAN  = 7'h7F;

    typedef struct packed {
        logic        sign;
        logic [4:0]  e16;
        logic [10:0] sig;
        logic [1:0]  cls;
    } lane_t;

    typedef struct packed {
        logic       ovf;
        logic [7:0] code;
    } q_t;

    function automatic lane_t unpack_lane(input logic [15:0] x);
        lane_t l;
        l.sign = x[15];
        l.e16  = x[14:10];
        l.sig  = {x[14:10] != 5'd0, x[9:0]};
        if (x[14:10] == 5'h1F)
            l.cls = (x[9:0] != 10'd0) ? CLS_NAN : CLS_INF;
        else if (x[14:10] == 5'd0)
            l.cls = CLS_ZERO;
        else
            l.cls = CLS_NORM;
        return l;
    endfunction

    function automatic logic [6:0] overflow_code(input logic e5);
        if (SATURATE)
            return e5 ? E5M2_MAX : E4M3_MAX;
        return e5 ? E5M2_INF : FP8_NAN;
    endfunction

    // E5M2 shares the FP16 exponent, so the top byte rounded on the low byte is the answer.
    function automatic q_t quant_e5m2(input lane_t l);
        logic       up;
        logic [7:0] mag;
        q_t         q;
        up     = l.sig[7] & (l.sig[8] | (|l.sig[6:0]));
        mag    = {1'b0, l.e16, l.sig[9:8]} + 8'(up);
        q.ovf  = 1'b0;
        q.code = {l.sign, mag[6:0]};
        if (l.cls == CLS_NAN) begin
            q.code = {l.sign, FP8_NAN};
        end else if (l.cls == CLS_INF || mag >= 8'h7C) begin
            q.ovf  = 1'b1;
            q.code = {l.sign, overflow_code(1'b1)};
        end
        return q;
    endfunction

    function automatic q_t quant_e4m3(input lane_t l);
        logic [4:0]  e8;
        logic [4:0]  sh;
        logic [13:0] ext;
        logic        up;
        logic [7:0]  mag;
        q_t          q;
        e8  = l.e16 - 5'd8;
        sh  = 5'd9 - l.e16;
        // Four guard bits below the significand keep every shifted-out bit for the sticky term.
        ext = 14'({l.sig, 4'b0000} >> sh);
        up  = 1'b0;
        mag = 8'd0;
        if (l.e16 >= 5'd9) begin
            up  = l.sig[6] & (l.sig[7] | (|l.sig[5:0]));
            mag = {e8, l.sig[9:7]} + 8'(up);
        end else if (l.e16 >= 5'd5) begin
            up  = ext[10] & (ext[11] | (|ext[9:0]));
            mag = {5'd0, ext[13:11]} + 8'(up);
        end
        q.ovf  = 1'b0;
        q.code = {l.sign, mag[6:0]};
        if (l.cls == CLS_NAN) begin
            q.code = {l.sign, FP8_NAN};
        end else if (l.cls == CLS_INF || mag > {1'b0, E4M3_MAX}) begin
            q.ovf  = 1'b1;
            q.code = {l.sign, overflow_code(1'b0)};
        end
        return q;
    endfunction

    lane_t [3:0] s1_lane;
    logic        s1_mode;
    logic        s1_full;
    logic        s2_full;
    logic        in_fire;
    logic        s2_load;
    logic [31:0] q_vec;
    logic [3:0]  q_of;
    q_t          q_lane;

    assign s2_load   = s1_full && (!s2_full || out_ready);
    assign in_ready  = !s1_full || !s2_full || out_ready;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = s2_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_full <= 1'b0;
            s2_full <= 1'b0;
        end else begin
            s1_full <= in_fire || (s1_full && !s2_load);
            s2_full <= s2_load || (s2_full && !out_ready);
        end
    end

    // NOTE: stage-1 payload is qualified by s1_full, so it carries no reset and only loads on a transfer.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_mode <= e5m2mode;
            for (int i = 0; i < 4; i++)
                s1_lane[i] <= unpack_lane(h[16*i +: 16]);
        end
    end

    always_comb begin
        q_vec  = '0;
        q_of   = '0;
        q_lane = '0;
        for (int i = 0; i < 4; i++) begin
            q_lane = s1_mode ? quant_e5m2(s1_lane[i]) : quant_e4m3(s1_lane[i]);
            q_vec[8*i +: 8] = q_lane.code;
            q_of[i]         = q_lane.ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec      <= '0;
            of_flags <= '0;
        end else if (s2_load) begin
            vec      <= q_vec;
            of_flags <= q_of;
        end
    end

endmodule
